// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle control FSM plus accumulator datapath that
// sits right after the fetch stage. Steady state is FETCH -> DECODE ->
// EXECUTE (3 cycles per instruction). FETCH_WAIT absorbs the registered
// program-memory read of address 0 after reset.
//
// Handshake with the fetch stage: IRload captures the memory output into IR
// at the end of FETCH; PCload updates the PC at the end of DECODE, to PC+1
// when Jmux=1 or to IR[ADDR_LEN-1:0] when Jmux=0. The new PC's memory read
// completes during EXECUTE, so IR is reloaded in the following FETCH.
module control_sequencer #(
    parameter int ADDR_LEN        = 4,
    parameter int INSTRUCTION_LEN = 10,
    parameter int DATA_LEN        = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [INSTRUCTION_LEN-1:0] IR,
    input  logic [DATA_LEN-1:0]        in_data,
    output logic                       PCload,
    output logic                       IRload,
    output logic                       Jmux,
    output logic [DATA_LEN-1:0]        acc,
    output logic                       zero,
    output logic                       carry,
    output logic [DATA_LEN-1:0]        out_data,
    output logic                       out_valid,
    output logic                       halted,
    output logic [2:0]                 state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH_WAIT = 3'd0,
        S_FETCH      = 3'd1,
        S_DECODE     = 3'd2,
        S_EXECUTE    = 3'd3,
        S_HALT       = 3'd4
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LDI  = 3'd1;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_SUBI = 3'd3;
    localparam logic [2:0] OP_IN   = 3'd4;
    localparam logic [2:0] OP_OUT  = 3'd5;
    localparam logic [2:0] OP_JZ   = 3'd6;
    localparam logic [2:0] OP_JMP  = 3'd7;

    // Immediate field width; the jump target must lie inside it, otherwise
    // jumps would read opcode bits as address bits and are never taken.
    localparam int IMM_LEN = 7;
    localparam bit TGT_FITS = (ADDR_LEN <= IMM_LEN);

    state_t state, next_state;

    logic [2:0]          opcode;
    logic                halt_bit;
    logic [DATA_LEN-1:0] imm;
    logic                is_halt;
    logic                jump_taken;
    logic [DATA_LEN:0]   sum;
    logic [DATA_LEN-1:0] diff;

    assign opcode   = IR[INSTRUCTION_LEN-1 -: 3];
    assign halt_bit = IR[IMM_LEN-1];
    assign imm      = DATA_LEN'(IR[IMM_LEN-1:0]);
    assign is_halt  = (opcode == OP_JMP) && halt_bit;
    // JZ looks at the registered flag, i.e. the result of the last A write.
    assign jump_taken = TGT_FITS &&
                        (((opcode == OP_JMP) && !halt_bit) ||
                         ((opcode == OP_JZ) && zero));

    assign sum  = {1'b0, acc} + {1'b0, imm};
    assign diff = acc - imm;

    assign state_dbg = state;
    assign halted    = (state == S_HALT);

    // State register; reset restarts the sequence at FETCH_WAIT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_FETCH_WAIT;
        else       state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH_WAIT: next_state = S_FETCH;
            S_FETCH:      next_state = S_DECODE;
            S_DECODE:     next_state = is_halt ? S_HALT : S_EXECUTE;
            S_EXECUTE:    next_state = S_FETCH;
            S_HALT:       next_state = S_HALT;
            default:      next_state = S_FETCH_WAIT;
        endcase
    end

    // Fetch-stage control; IR is only looked at in DECODE.
    always_comb begin
        PCload = 1'b0;
        IRload = 1'b0;
        Jmux   = 1'b1;
        case (state)
            S_FETCH: IRload = 1'b1;
            S_DECODE: begin
                if (!is_halt) begin
                    PCload = 1'b1;
                    Jmux   = !jump_taken;
                end
            end
            default: ;
        endcase
    end

    // Datapath: register writes happen at the EXECUTE edge only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state == S_EXECUTE) begin
                case (opcode)
                    OP_LDI: begin
                        acc  <= imm;
                        zero <= (imm == '0);
                    end
                    OP_ADDI: begin
                        acc   <= sum[DATA_LEN-1:0];
                        carry <= sum[DATA_LEN];
                        zero  <= (sum[DATA_LEN-1:0] == '0);
                    end
                    OP_SUBI: begin
                        acc   <= diff;
                        carry <= (acc < imm);
                        zero  <= (diff == '0);
                    end
                    OP_IN: begin
                        acc  <= in_data;
                        zero <= (in_data == '0);
                    end
                    OP_OUT: begin
                        out_data  <= acc;
                        out_valid <= 1'b1;
                    end
                    OP_NOP, OP_JZ, OP_JMP: ;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: includes a small model of the fetch stage
// (PC, registered program memory, IR) and runs directed programs.
module tb_control_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] ir;
    logic [7:0] in_data = 8'h00;
    logic       pc_load, ir_load, jmux;
    logic [7:0] acc, out_data;
    logic       zero, carry, out_valid, halted;
    logic [2:0] state_dbg;

    logic [9:0] mem [16];
    logic [9:0] mem_q;
    logic [3:0] pc;

    int total = 0;
    int bad   = 0;

    localparam logic [9:0] HALT_W = 10'h3C0;

    // Clock generation.
    always #5 clock = ~clock;

    // Fetch stage model: registered memory read, PC and IR registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc    <= 4'd0;
            mem_q <= 10'd0;
            ir    <= 10'd0;
        end else begin
            mem_q <= mem[pc];
            if (pc_load) pc <= jmux ? pc + 4'd1 : ir[3:0];
            if (ir_load) ir <= mem_q;
        end
    end

    control_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .IR        (ir),
        .in_data   (in_data),
        .PCload    (pc_load),
        .IRload    (ir_load),
        .Jmux      (jmux),
        .acc       (acc),
        .zero      (zero),
        .carry     (carry),
        .out_data  (out_data),
        .out_valid (out_valid),
        .halted    (halted),
        .state_dbg (state_dbg)
    );

    function automatic logic [9:0] ins(input logic [2:0] op, input logic [6:0] imm);
        return {op, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = HALT_W;
    endtask

    // Reset over one rising edge; returns right after release at a negedge.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Advance to the next DECODE cycle (sampled at negedge), bounded.
    task automatic wait_decode(input string tag);
        int n = 0;
        @(negedge clock);
        while (state_dbg != 3'd2 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_reach_decode"}, 32'(state_dbg), 32'd2);
    endtask

    initial begin
        int vcnt;
        int pcl_cnt;
        int not_halt;
        logic [7:0] seen_out;

        // ---- Test 1: reset values and state sequence ----
        clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = ins(3'd0, 7'd0);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_acc", 32'(acc), 32'd0);
        check("rst_flags", 32'({zero, carry, out_valid, halted}), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_en", 32'({pc_load, ir_load}), 32'd0);
        reset = 1'b0;
        // cycle 1 after release: FETCH_WAIT
        check("c1_state", 32'(state_dbg), 32'd0);
        check("c1_irload", 32'(ir_load), 32'd0);
        @(negedge clock);
        check("c2_state", 32'(state_dbg), 32'd1);
        check("c2_irload", 32'(ir_load), 32'd1);
        check("c2_pcload", 32'(pc_load), 32'd0);
        @(negedge clock);
        check("c3_state", 32'(state_dbg), 32'd2);
        check("c3_pcload_jmux", 32'({pc_load, jmux, ir_load}), 32'b110);
        @(negedge clock);
        check("c4_state", 32'(state_dbg), 32'd3);
        check("c4_pcload", 32'(pc_load), 32'd0);
        @(negedge clock);
        check("c5_state", 32'(state_dbg), 32'd1);
        @(negedge clock);
        check("c6_state", 32'(state_dbg), 32'd2);
        @(negedge clock);
        check("c7_state", 32'(state_dbg), 32'd3);

        // ---- Test 2: LDI 3; SUBI 3; JZ 6 taken ----
        clear_mem();
        mem[0] = ins(3'd1, 7'd3);
        mem[1] = ins(3'd3, 7'd3);
        mem[2] = ins(3'd6, 7'd6);
        mem[3] = ins(3'd1, 7'h55);
        mem[6] = ins(3'd1, 7'h42);
        do_reset();
        wait_decode("t2_ldi");
        wait_decode("t2_subi");
        check("t2_acc_before_sub", 32'(acc), 32'd3);
        wait_decode("t2_jz");
        check("t2_acc", 32'(acc), 32'd0);
        check("t2_zero", 32'(zero), 32'd1);
        check("t2_carry", 32'(carry), 32'd0);
        check("t2_jz_ctrl", 32'({pc_load, jmux}), 32'b10);
        wait_decode("t2_target");
        check("t2_ir_from_6", 32'(ir), 32'(ins(3'd1, 7'h42)));
        wait_decode("t2_after");
        check("t2_acc_42", 32'(acc), 32'h42);
        check("t2_zero_clr", 32'(zero), 32'd0);

        // ---- Test 3: ADDI carry ----
        clear_mem();
        mem[0] = ins(3'd1, 7'h7F);
        mem[1] = ins(3'd2, 7'h7F);
        mem[2] = ins(3'd2, 7'h7F);
        do_reset();
        wait_decode("t3_ldi");
        wait_decode("t3_add1");
        check("t3_acc_7f", 32'(acc), 32'h7F);
        wait_decode("t3_add2");
        check("t3_acc_fe", 32'(acc), 32'hFE);
        check("t3_carry0", 32'(carry), 32'd0);
        wait_decode("t3_halt");
        check("t3_acc_7d", 32'(acc), 32'h7D);
        check("t3_carry1", 32'(carry), 32'd1);
        check("t3_zero0", 32'(zero), 32'd0);
        check("t3_halt_pcload", 32'(pc_load), 32'd0);
        @(negedge clock);
        check("t3_halted", 32'({halted, state_dbg}), 32'({1'b1, 3'd4}));

        // ---- Test 4: SUBI borrow, JZ not taken ----
        clear_mem();
        mem[0] = ins(3'd1, 7'd2);
        mem[1] = ins(3'd3, 7'd3);
        mem[2] = ins(3'd6, 7'd9);
        mem[9] = ins(3'd1, 7'h11);
        do_reset();
        wait_decode("t4_ldi");
        wait_decode("t4_subi");
        wait_decode("t4_jz");
        check("t4_acc_ff", 32'(acc), 32'hFF);
        check("t4_carry1", 32'(carry), 32'd1);
        check("t4_zero0", 32'(zero), 32'd0);
        check("t4_jz_ctrl", 32'({pc_load, jmux}), 32'b11);
        wait_decode("t4_next");
        check("t4_ir_from_3", 32'(ir), 32'(HALT_W));

        // ---- Test 5: IN, OUT, HALT ----
        clear_mem();
        mem[0] = ins(3'd4, 7'd0);
        mem[1] = ins(3'd5, 7'd0);
        in_data = 8'hA5;
        do_reset();
        wait_decode("t5_in");
        wait_decode("t5_out");
        check("t5_acc_a5", 32'(acc), 32'hA5);
        check("t5_carry_kept", 32'(carry), 32'd0);
        vcnt = 0;
        seen_out = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (out_valid) begin
                vcnt++;
                seen_out = out_data;
            end
        end
        check("t5_valid_cycles", 32'(vcnt), 32'd1);
        check("t5_out_data", 32'(seen_out), 32'hA5);
        check("t5_halted", 32'({halted, state_dbg}), 32'({1'b1, 3'd4}));
        pcl_cnt = 0;
        not_halt = 0;
        in_data = 8'h3C;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (pc_load || ir_load) pcl_cnt++;
            if (!halted || state_dbg != 3'd4) not_halt++;
        end
        check("t5_halt_no_enables", 32'(pcl_cnt), 32'd0);
        check("t5_halt_stays", 32'(not_halt), 32'd0);
        check("t5_halt_acc_kept", 32'(acc), 32'hA5);

        // ---- Test 6: async reset during EXECUTE of LDI 0x10 ----
        clear_mem();
        mem[0] = ins(3'd1, 7'h33);
        mem[1] = ins(3'd5, 7'd0);
        mem[2] = ins(3'd1, 7'h10);
        do_reset();
        wait_decode("t6_ldi33");
        wait_decode("t6_out");
        wait_decode("t6_ldi10");
        check("t6_acc_33", 32'(acc), 32'h33);
        @(negedge clock);
        check("t6_in_execute", 32'(state_dbg), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("t6_acc_cleared", 32'(acc), 32'd0);
        check("t6_state0", 32'(state_dbg), 32'd0);
        check("t6_out_regs", 32'({out_valid, out_data}), 32'd0);
        check("t6_flags", 32'({zero, carry, halted}), 32'd0);
        @(negedge clock);
        check("t6_acc_held", 32'(acc), 32'd0);
        reset = 1'b0;
        wait_decode("t6_restart");
        check("t6_ir_from_0", 32'(ir), 32'(ins(3'd1, 7'h33)));
        check("t6_acc_still0", 32'(acc), 32'd0);
        wait_decode("t6_restart2");
        check("t6_acc_33_again", 32'(acc), 32'h33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
